action_sequencer: RTL and testbench
===================================

Name: action_sequencer

Overview:
Process controller that runs a fixed fill → mix → drain cycle and drives the actuators for each step. It publishes the current step as a 3-bit action code, action[2:0] = {A,B,C} with A as the MSB. That code feeds the 7-segment action-digit decoder directly downstream. All outputs are registered, so the decoder sees a glitch-free code.

Parameters:
TICK_DIV, 50_000_000, clk cycles per timing tick (1 s at 50 MHz); benches use 4
FILL_TIMEOUT, 10, ticks allowed in FILL before level_hi is required
MIX_TICKS, 5, exact MIX duration in ticks
DRAIN_TIMEOUT, 10, ticks allowed in DRAIN before level_lo is required
DONE_TICKS, 2, ticks DONE is held before returning to IDLE

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  debounced start/resume button, level, active-high
stop  in  1  debounced stop/abort/clear button, level, active-high
level_hi  in  1  tank-full sensor
level_lo  in  1  tank-empty sensor
action  out  3  current step code, to the digit decoder
valve_in  out  1  inlet valve
motor  out  1  mixer motor
valve_out  out  1  outlet valve
busy  out  1  high in FILL, MIX, DRAIN, PAUSE
done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Single clk domain. Reset is synchronous, active-low: rst_n sampled low at a rising clk edge resets the block. This holds mid-operation.
- Reset values: state IDLE, action=000, all actuators 0, busy=0, done=0. Timer, prescaler and edge registers are 0, saved_state is IDLE.
- Action codes: IDLE 000, FILL 001, MIX 010, DRAIN 011, DONE 100, ERROR 101, PAUSE 110. Code 111 is never driven.
- The action register updates on the same edge as the state register.
- Edge detect: start_e = start & ~start_q and stop_e = stop & ~stop_q, using one registered copy of each input. Holding a button produces exactly one event.
- Tick generator:
  - Prescaler counts 0..TICK_DIV-1; tick=1 for one cycle when it equals TICK_DIV-1, then it wraps to 0.
  - Prescaler and the tick timer are both cleared on every state transition.
  - Each state's tick count is therefore exact: MIX lasts exactly MIX_TICKS*TICK_DIV cycles.
- Transitions, evaluated in this priority order:
  1. Sensor fault (level_hi & level_lo) in FILL, MIX or DRAIN → ERROR.
  2. stop_e in FILL, MIX or DRAIN → PAUSE; saved_state is set to the current state.
  3. State-specific rules:
     - IDLE: start_e → FILL.
     - FILL: valve_in=1. level_hi → MIX. Timer reaching FILL_TIMEOUT → ERROR. If both occur on the same cycle, level_hi wins.
     - MIX: motor=1. Timer reaching MIX_TICKS → DRAIN.
     - DRAIN: valve_out=1. level_lo → DONE. Timer reaching DRAIN_TIMEOUT → ERROR; level_lo wins a tie.
     - DONE: done pulses on the entry cycle. Timer reaching DONE_TICKS → IDLE. start_e and stop_e are ignored.
     - PAUSE: actuators 0; timer and prescaler frozen (not cleared).
       - start_e → saved_state, with timer and prescaler resumed from their frozen values.
       - stop_e → IDLE (abort).
       - Simultaneous start_e and stop_e → IDLE (stop wins).
     - ERROR: actuators 0. stop_e → IDLE; start_e is ignored.
- Actuator outputs are registered and decoded from the next state, so they change on the same edge as action. Actuators are mutually exclusive.
- Timer width is $clog2 of the largest tick parameter, plus 1. It saturates and never wraps.

Decomposition:
- Shared package action_pkg:
  - 3-bit state/action enum with the codes above.
  - ACTION_W=3.
- Sub-module tick_gen:
  - Prescaler with TICK_DIV parameter.
  - Inputs clk, rst_n, clr, hold; output tick.
- All state logic stays in action_sequencer; expected size is about 200 lines.

Test Plan (TICK_DIV=4):
1. Reset then run:
   - rst_n low for 2 cycles → action=000, all outputs 0.
   - Start pulse → action=001 and valve_in=1 on the next edge.
   - level_hi → action=010 and motor=1.
   - After 20 cycles → action=011.
   - level_lo → action=100 with done=1 for one cycle.
   - After 8 cycles → action=000.
2. Fill timeout: start, never assert level_hi → action=101 exactly 40 cycles after FILL entry, actuators 0. A start press in ERROR is ignored; stop → 000.
3. Pause/resume:
   - Stop at MIX cycle 9 → action=110, motor=0.
   - Wait 30 cycles, press start → action=010.
   - DRAIN is reached after exactly 11 more cycles.
4. Sensor fault: level_hi=level_lo=1 during DRAIN → 101 on the next edge, even with stop asserted on the same cycle.
5. Reset mid-MIX: rst_n low for 1 cycle → action=000, motor=0 on that edge. A held start does not retrigger without a new rising edge.
6. PAUSE with start and stop rising on the same cycle → action=000, busy=0.

Source files
------------

// File: rtl/action_pkg.sv
// Shared types for the fill/mix/drain action sequencer.
// The state encoding is the action code seen by the digit decoder.
package action_pkg;

   localparam int ACTION_W = 3;

   typedef enum logic [ACTION_W-1:0] {
      ST_IDLE  = 3'b000,
      ST_FILL  = 3'b001,
      ST_MIX   = 3'b010,
      ST_DRAIN = 3'b011,
      ST_DONE  = 3'b100,
      ST_ERROR = 3'b101,
      ST_PAUSE = 3'b110
   } state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks.
// clr restarts the count; hold freezes it and suppresses the tick.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST) && !hold;
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (hold)
         cnt_d = cnt_q;
      else if (tick)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/action_sequencer.sv
// Fill -> mix -> drain process controller with pause/resume and fault handling.
// All outputs are registered from the next state so they move with action.
module action_sequencer
   import action_pkg::*;
#(
   parameter int TICK_DIV      = 50_000_000,
   parameter int FILL_TIMEOUT  = 10,
   parameter int MIX_TICKS     = 5,
   parameter int DRAIN_TIMEOUT = 10,
   parameter int DONE_TICKS    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                level_hi,
   input  logic                level_lo,
   output logic [ACTION_W-1:0] action,
   output logic                valve_in,
   output logic                motor,
   output logic                valve_out,
   output logic                busy,
   output logic                done
);

   localparam int TMAX = max_of(max_of(FILL_TIMEOUT, MIX_TICKS), max_of(DRAIN_TIMEOUT, DONE_TICKS));
   localparam int TW   = $clog2(TMAX) + 1;
   localparam logic [TW-1:0] T_SAT   = {TW{1'b1}};
   localparam logic [TW-1:0] T_FILL  = TW'(FILL_TIMEOUT);
   localparam logic [TW-1:0] T_MIX   = TW'(MIX_TICKS);
   localparam logic [TW-1:0] T_DRAIN = TW'(DRAIN_TIMEOUT);
   localparam logic [TW-1:0] T_DONE  = TW'(DONE_TICKS);

   state_e        state_q, state_d;
   state_e        saved_q, saved_d;
   logic          start_q, stop_q;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic          valve_in_q, valve_in_d;
   logic          motor_q, motor_d;
   logic          valve_out_q, valve_out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          start_e, stop_e, fault, running;
   logic          tick, clr, hold;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .hold  (hold),
      .tick  (tick)
   );

   always_comb begin
      start_e   = start & ~start_q;
      stop_e    = stop & ~stop_q;
      fault     = level_hi & level_lo;
      running   = (state_q == ST_FILL) || (state_q == ST_MIX) || (state_q == ST_DRAIN);
      hold      = (state_q == ST_PAUSE);
      // Timeouts compare against the post-tick value so a state lasts exactly N ticks.
      timer_inc = (tick && (timer_q != T_SAT)) ? timer_q + 1'b1 : timer_q;
      state_d   = state_q;
      saved_d   = saved_q;

      if (running && fault) begin
         state_d = ST_ERROR;
      end else if (running && stop_e) begin
         state_d = ST_PAUSE;
         saved_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE:  if (start_e) state_d = ST_FILL;
            ST_FILL: begin
               if (level_hi)                 state_d = ST_MIX;
               else if (timer_inc >= T_FILL) state_d = ST_ERROR;
            end
            ST_MIX:   if (timer_inc >= T_MIX) state_d = ST_DRAIN;
            ST_DRAIN: begin
               if (level_lo)                  state_d = ST_DONE;
               else if (timer_inc >= T_DRAIN) state_d = ST_ERROR;
            end
            ST_DONE:  if (timer_inc >= T_DONE) state_d = ST_IDLE;
            ST_PAUSE: begin
               if (stop_e)       state_d = ST_IDLE;
               else if (start_e) state_d = saved_q;
            end
            ST_ERROR: if (stop_e) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      // Entering or leaving PAUSE toward the saved step keeps the timing context.
      clr = (state_d != state_q) && (state_d != ST_PAUSE) &&
            !((state_q == ST_PAUSE) && (state_d != ST_IDLE));
      timer_d = clr ? '0 : timer_inc;

      valve_in_d  = (state_d == ST_FILL);
      motor_d     = (state_d == ST_MIX);
      valve_out_d = (state_d == ST_DRAIN);
      busy_d      = (state_d == ST_FILL) || (state_d == ST_MIX) ||
                    (state_d == ST_DRAIN) || (state_d == ST_PAUSE);
      done_d      = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         saved_q     <= ST_IDLE;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         timer_q     <= '0;
         valve_in_q  <= 1'b0;
         motor_q     <= 1'b0;
         valve_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         start_q     <= start;
         stop_q      <= stop;
         timer_q     <= timer_d;
         valve_in_q  <= valve_in_d;
         motor_q     <= motor_d;
         valve_out_q <= valve_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign action    = state_q;
   assign valve_in  = valve_in_q;
   assign motor     = motor_q;
   assign valve_out = valve_out_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer with TICK_DIV=4.
// Observed vector is {action, valve_in, motor, valve_out, busy, done}.
module tb_action_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       level_hi = 1'b0;
   logic       level_lo = 1'b0;
   logic [2:0] action;
   logic       valve_in, motor, valve_out, busy, done;
   logic [7:0] obs;
   int         checks = 0;
   int         errors = 0;

   localparam logic [7:0] V_IDLE  = 8'b000_00000;
   localparam logic [7:0] V_FILL  = 8'b001_10010;
   localparam logic [7:0] V_MIX   = 8'b010_01010;
   localparam logic [7:0] V_DRAIN = 8'b011_00110;
   localparam logic [7:0] V_DONE1 = 8'b100_00001;
   localparam logic [7:0] V_DONE  = 8'b100_00000;
   localparam logic [7:0] V_ERROR = 8'b101_00000;
   localparam logic [7:0] V_PAUSE = 8'b110_00010;

   action_sequencer #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .level_hi  (level_hi),
      .level_lo  (level_lo),
      .action    (action),
      .valve_in  (valve_in),
      .motor     (motor),
      .valve_out (valve_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   assign obs = {action, valve_in, motor, valve_out, busy, done};

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset obs=%b exp=%b", obs, V_IDLE); end
      rst_n = 1'b1;
      step(1);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, V_IDLE); end
   endtask

   task automatic test_run();
      start = 1'b1; step(1); start = 1'b0;
      checks++; if (obs !== V_FILL) begin errors++; $display("FAIL run_fill obs=%b exp=%b", obs, V_FILL); end
      level_hi = 1'b1; step(1); level_hi = 1'b0;
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL run_mix obs=%b exp=%b", obs, V_MIX); end
      step(19);
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL run_mix_19 obs=%b exp=%b", obs, V_MIX); end
      step(1);
      checks++; if (obs !== V_DRAIN) begin errors++; $display("FAIL run_drain_20 obs=%b exp=%b", obs, V_DRAIN); end
      level_lo = 1'b1; step(1); level_lo = 1'b0;
      checks++; if (obs !== V_DONE1) begin errors++; $display("FAIL run_done_pulse obs=%b exp=%b", obs, V_DONE1); end
      step(1);
      checks++; if (obs !== V_DONE) begin errors++; $display("FAIL run_done_hold obs=%b exp=%b", obs, V_DONE); end
      step(6);
      checks++; if (obs !== V_DONE) begin errors++; $display("FAIL run_done_7 obs=%b exp=%b", obs, V_DONE); end
      step(1);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL run_idle_8 obs=%b exp=%b", obs, V_IDLE); end
   endtask

   task automatic test_fill_timeout();
      start = 1'b1; step(1); start = 1'b0;
      checks++; if (obs !== V_FILL) begin errors++; $display("FAIL to_fill obs=%b exp=%b", obs, V_FILL); end
      step(39);
      checks++; if (obs !== V_FILL) begin errors++; $display("FAIL to_fill_39 obs=%b exp=%b", obs, V_FILL); end
      step(1);
      checks++; if (obs !== V_ERROR) begin errors++; $display("FAIL to_error_40 obs=%b exp=%b", obs, V_ERROR); end
      start = 1'b1; step(1); start = 1'b0; step(1);
      checks++; if (obs !== V_ERROR) begin errors++; $display("FAIL to_start_ignored obs=%b exp=%b", obs, V_ERROR); end
      stop = 1'b1; step(1); stop = 1'b0; step(1);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL to_stop_clear obs=%b exp=%b", obs, V_IDLE); end
   endtask

   task automatic test_pause_resume();
      start = 1'b1; step(1); start = 1'b0;
      level_hi = 1'b1; step(1); level_hi = 1'b0;
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL pr_mix obs=%b exp=%b", obs, V_MIX); end
      step(8);
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (obs !== V_PAUSE) begin errors++; $display("FAIL pr_pause obs=%b exp=%b", obs, V_PAUSE); end
      step(30);
      checks++; if (obs !== V_PAUSE) begin errors++; $display("FAIL pr_pause_30 obs=%b exp=%b", obs, V_PAUSE); end
      start = 1'b1; step(1); start = 1'b0;
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL pr_resume obs=%b exp=%b", obs, V_MIX); end
      step(10);
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL pr_mix_10 obs=%b exp=%b", obs, V_MIX); end
      step(1);
      checks++; if (obs !== V_DRAIN) begin errors++; $display("FAIL pr_drain_11 obs=%b exp=%b", obs, V_DRAIN); end
   endtask

   task automatic test_sensor_fault();
      level_hi = 1'b1; level_lo = 1'b1; stop = 1'b1; step(1);
      level_hi = 1'b0; level_lo = 1'b0; stop = 1'b0;
      checks++; if (obs !== V_ERROR) begin errors++; $display("FAIL fault_error obs=%b exp=%b", obs, V_ERROR); end
      step(1);
      stop = 1'b1; step(1); stop = 1'b0; step(1);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL fault_clear obs=%b exp=%b", obs, V_IDLE); end
   endtask

   task automatic test_reset_mid_mix();
      start = 1'b1; step(1);
      level_hi = 1'b1; step(1); level_hi = 1'b0;
      step(3);
      checks++; if (obs !== V_MIX) begin errors++; $display("FAIL rm_held_start obs=%b exp=%b", obs, V_MIX); end
      start = 1'b0;
      rst_n = 1'b0; step(1); rst_n = 1'b1;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL rm_reset obs=%b exp=%b", obs, V_IDLE); end
      step(3);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL rm_stay_idle obs=%b exp=%b", obs, V_IDLE); end
      start = 1'b1; step(1);
      checks++; if (obs !== V_FILL) begin errors++; $display("FAIL rm_new_edge obs=%b exp=%b", obs, V_FILL); end
      step(5);
      checks++; if (obs !== V_FILL) begin errors++; $display("FAIL rm_hold_fill obs=%b exp=%b", obs, V_FILL); end
      stop = 1'b1; step(1); stop = 1'b0;
      checks++; if (obs !== V_PAUSE) begin errors++; $display("FAIL rm_pause obs=%b exp=%b", obs, V_PAUSE); end
   endtask

   task automatic test_pause_both();
      start = 1'b0; step(1);
      start = 1'b1; stop = 1'b1; step(1);
      start = 1'b0; stop = 1'b0;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL both_abort obs=%b exp=%b", obs, V_IDLE); end
      step(2);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL both_idle obs=%b exp=%b", obs, V_IDLE); end
   endtask

   initial begin
      step(1);
      test_reset();
      test_run();
      test_fill_timeout();
      test_pause_resume();
      test_sensor_fault();
      test_reset_mid_mix();
      test_pause_both();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
